// File: rtl/wave_mem_loader_pkg.sv
// Shared tone-generator constants and types: wave memory geometry, sample
// width and the loader state encoding, used by the loader and the wave memory.
package wave_mem_loader_pkg;

  localparam int WAVE_DEPTH    = 32;
  localparam int WAVE_ADDR_W   = 5;
  localparam int WAVE_SAMPLE_W = 4;
  localparam int WAVE_BYTE_W   = 2 * WAVE_SAMPLE_W;
  localparam int WAVE_LEN_W    = 6;

  localparam logic [WAVE_LEN_W-1:0] LEN_ONE  = 6'd1;
  localparam logic [WAVE_LEN_W-1:0] LEN_FULL = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_WR_HI     = 3'd2,
    ST_WR_LO     = 3'd3,
    ST_DONE      = 3'd4
  } load_state_e;

  // A zero length or any length beyond the memory depth loads the whole table.
  function automatic logic [WAVE_LEN_W-1:0] norm_len(input logic [WAVE_LEN_W-1:0] len);
    logic [WAVE_LEN_W-1:0] res;
    if ((len == 6'd0) || (len > LEN_FULL)) begin
      res = LEN_FULL;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/wave_mem_loader_if.sv
// Load-request, byte-stream and wave-memory write bus of the wave loader.
// master = stimulus/controller side, slave = the loader itself.
interface wave_mem_loader_if import wave_mem_loader_pkg::*; ();

  logic                     load_start_in;
  logic [WAVE_ADDR_W-1:0]   load_addr_in;
  logic [WAVE_LEN_W-1:0]    load_len_in;
  logic [WAVE_BYTE_W-1:0]   byte_data_in;
  logic                     byte_valid_in;
  logic                     byte_ready_out;
  logic [WAVE_ADDR_W-1:0]   mem_write_addr_out;
  logic [WAVE_SAMPLE_W-1:0] mem_write_data_out;
  logic                     mem_write_en_out;
  logic                     busy_out;
  logic                     done_out;

  modport master (
    output load_start_in,
    output load_addr_in,
    output load_len_in,
    output byte_data_in,
    output byte_valid_in,
    input  byte_ready_out,
    input  mem_write_addr_out,
    input  mem_write_data_out,
    input  mem_write_en_out,
    input  busy_out,
    input  done_out
  );

  modport slave (
    input  load_start_in,
    input  load_addr_in,
    input  load_len_in,
    input  byte_data_in,
    input  byte_valid_in,
    output byte_ready_out,
    output mem_write_addr_out,
    output mem_write_data_out,
    output mem_write_en_out,
    output busy_out,
    output done_out
  );

endinterface

// File: rtl/wave_mem_loader.sv
// Streams packed byte pairs of samples into the wave memory, high nibble
// first, starting at a captured address for a captured number of samples.
module wave_mem_loader import wave_mem_loader_pkg::*; #(
  parameter int ADDR_W   = WAVE_ADDR_W,
  parameter int SAMPLE_W = WAVE_SAMPLE_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  wave_mem_loader_if.slave bus
);

  localparam int BYTE_W = 2 * SAMPLE_W;

  load_state_e             state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [WAVE_LEN_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]       byte_q, byte_d;
  logic                    ready_q, ready_d;
  logic                    wen_q, wen_d;
  logic [SAMPLE_W-1:0]     data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Next-state, address/count bookkeeping and byte capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_start_in) begin
          addr_d  = ADDR_W'(bus.load_addr_in);
          cnt_d   = norm_len(bus.load_len_in);
          state_d = ST_WAIT_BYTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_BYTE: begin
        if (bus.byte_valid_in) begin
          byte_d  = BYTE_W'(bus.byte_data_in);
          state_d = ST_WR_HI;
        end else begin
          state_d = ST_WAIT_BYTE;
        end
      end
      ST_WR_HI: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q - LEN_ONE;
        if (cnt_q == LEN_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WR_LO;
        end
      end
      ST_WR_LO: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q - LEN_ONE;
        if (cnt_q == LEN_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT_BYTE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output flops are loaded from the upcoming state so they line up with it.
  always_comb begin
    ready_d = (state_d == ST_WAIT_BYTE);
    wen_d   = (state_d == ST_WR_HI) || (state_d == ST_WR_LO);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    case (state_d)
      ST_WR_HI: data_d = byte_d[BYTE_W-1:SAMPLE_W];
      ST_WR_LO: data_d = byte_d[SAMPLE_W-1:0];
      default:  data_d = '0;
    endcase
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      ready_q <= ready_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // addr_q already holds the address of the sample being strobed.
  always_comb begin
    bus.byte_ready_out     = ready_q;
    bus.mem_write_addr_out = WAVE_ADDR_W'(addr_q);
    bus.mem_write_data_out = WAVE_SAMPLE_W'(data_q);
    bus.mem_write_en_out   = wen_q;
    bus.busy_out           = busy_q;
    bus.done_out           = done_q;
  end

endmodule

// File: tb/tb_wave_mem_loader.sv
// Scoreboard bench for wave_mem_loader: a sample-level model queues expected
// writes and the done pulse; a negedge monitor compares what the loader emits.
module tb_wave_mem_loader;
  import wave_mem_loader_pkg::*;

  typedef struct {
    bit is_done;
    int addr;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wave_mem_loader_if bus ();

  wave_mem_loader #(.ADDR_W(5), .SAMPLE_W(4)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   writes_seen = 0;
  int   dones_seen  = 0;
  bit   hs_pending  = 1'b0;
  bit   done_prev   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: sample i comes from byte i/2, high nibble on even i.
  task automatic model_load(input int a, input int len, input logic [7:0] bytes[$]);
    int   n;
    exp_t e;
    n = (len == 0 || len >= WAVE_DEPTH) ? WAVE_DEPTH : len;
    for (int i = 0; i < n; i++) begin
      e.is_done = 1'b0;
      e.addr    = (a + i) % WAVE_DEPTH;
      e.data    = (i % 2 == 0) ? (int'(bytes[i / 2]) / 16) : (int'(bytes[i / 2]) % 16);
      exp_q.push_back(e);
    end
    e.is_done = 1'b1;
    e.addr    = 0;
    e.data    = 0;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every strobe / done pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hs_pending = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (hs_pending) chk("strobe_after_handshake", bus.mem_write_en_out, 1'b1);
      if (done_prev) chk("busy_after_done", bus.busy_out, 1'b0);
      chk("ready_with_strobe", bus.byte_ready_out & bus.mem_write_en_out, 1'b0);
      if (bus.mem_write_en_out || bus.done_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {bus.mem_write_en_out, bus.done_out}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done) begin
            chk("done_pulse", bus.done_out, 1'b1);
            chk("strobe_in_done", bus.mem_write_en_out, 1'b0);
            dones_seen++;
          end else begin
            chk("write_en", bus.mem_write_en_out, 1'b1);
            chk("write_addr", bus.mem_write_addr_out, e.addr);
            chk("write_data", bus.mem_write_data_out, e.data);
            writes_seen++;
          end
          chk("busy_during_output", bus.busy_out, 1'b1);
        end
      end
      hs_pending = bus.byte_ready_out && bus.byte_valid_in;
      done_prev  = bus.done_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    bus.byte_valid_in = 1'b1;
    bus.byte_data_in  = b;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = bus.byte_ready_out;
      tick();
    end
    if (!acc) chk("handshake_timeout", 32'd0, 32'd1);
    bus.byte_valid_in = 1'b0;
    bus.byte_data_in  = 8'($urandom);
  endtask

  task automatic run_load(input int a, input int len, input logic [7:0] bytes[$],
                          input int max_gap, input bit poke_start);
    int d0;
    int n;
    d0 = dones_seen;
    n  = (len == 0 || len >= WAVE_DEPTH) ? WAVE_DEPTH : len;
    model_load(a, len, bytes);
    bus.load_start_in = 1'b1;
    bus.load_addr_in  = 5'(a);
    bus.load_len_in   = 6'(len);
    tick();
    bus.load_start_in = 1'b0;
    for (int k = 0; k < (n + 1) / 2; k++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        bus.byte_data_in = 8'($urandom);
        if (poke_start) begin
          bus.load_start_in = 1'($urandom);
          bus.load_addr_in  = 5'($urandom);
          bus.load_len_in   = 6'($urandom);
        end
        tick();
        bus.load_start_in = 1'b0;
      end
      send_byte(bytes[k]);
    end
    for (int c = 0; c < 40 && dones_seen == d0; c++) tick();
    chk("done_count", dones_seen, d0 + 1);
    chk("queue_drained", exp_q.size(), 0);
    tick();
  endtask

  function automatic void counting_bytes(output logic [7:0] q[$]);
    q = {};
    for (int k = 0; k < 16; k++) q.push_back(8'((2 * k) * 16 + (2 * k + 1)));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, wanted finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    int w0;
    int d0;
    bus.load_start_in = 1'b0;
    bus.load_addr_in  = 5'd0;
    bus.load_len_in   = 6'd0;
    bus.byte_data_in  = 8'd0;
    bus.byte_valid_in = 1'b0;

    #1;
    chk("rst_ready", bus.byte_ready_out, 1'b0);
    chk("rst_wen", bus.mem_write_en_out, 1'b0);
    chk("rst_busy", bus.busy_out, 1'b0);
    chk("rst_done", bus.done_out, 1'b0);
    chk("rst_addr", bus.mem_write_addr_out, 5'd0);
    chk("rst_data", bus.mem_write_data_out, 4'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Full table, back-to-back bytes.
    counting_bytes(bq);
    run_load(0, 0, bq, 0, 1'b0);

    // Wrap past address 31.
    bq = {8'hAB, 8'hCD};
    run_load(30, 4, bq, 0, 1'b0);

    // Odd length: trailing low nibble dropped.
    bq = {8'h12, 8'h34};
    run_load(5, 3, bq, 0, 1'b0);

    // Gapped valid and start pulses while busy.
    bq = {8'h9E, 8'h51, 8'h7C};
    run_load(12, 6, bq, 3, 1'b1);

    // Randomised loads, including out-of-range lengths.
    for (int r = 0; r < 6; r++) begin
      int a;
      int len;
      a   = int'($urandom_range(0, 31));
      len = int'($urandom_range(0, 63));
      bq  = {};
      for (int k = 0; k < 16; k++) bq.push_back(8'($urandom));
      run_load(a, len, bq, int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset right after the second strobe of a len=8 load.
    bq = {8'h5A, 8'hC3, 8'h0F, 8'hF0};
    w0 = writes_seen;
    d0 = dones_seen;
    model_load(20, 8, bq);
    bus.load_start_in = 1'b1;
    bus.load_addr_in  = 5'd20;
    bus.load_len_in   = 6'd8;
    tick();
    bus.load_start_in = 1'b0;
    send_byte(bq[0]);
    for (int c = 0; c < 20 && writes_seen < w0 + 2; c++) tick();
    chk("strobes_before_reset", writes_seen, w0 + 2);
    bus.byte_valid_in = 1'b1;
    bus.byte_data_in  = bq[1];
    rst = 1'b1;
    #1;
    chk("arst_ready", bus.byte_ready_out, 1'b0);
    chk("arst_wen", bus.mem_write_en_out, 1'b0);
    chk("arst_busy", bus.busy_out, 1'b0);
    chk("arst_done", bus.done_out, 1'b0);
    chk("arst_addr", bus.mem_write_addr_out, 5'd0);
    chk("arst_data", bus.mem_write_data_out, 4'd0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    bus.byte_valid_in = 1'b0;
    chk("no_strobe_after_reset", writes_seen, w0 + 2);
    chk("no_done_after_reset", dones_seen, d0);

    counting_bytes(bq);
    run_load(0, 0, bq, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
